// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, redirect/flush and halt FSM.
// Optional return-address stack is built only when FETCH_RAS_EN is defined.
module fetch_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [4:0] HALT_OPCODE = 5'b11111,
    parameter int         RAS_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_EN,
    input  logic [7:0]  BRANCH_TARGET,
    input  logic        PUSH,
    input  logic        POP,
    input  logic [15:0] DATA,
    output logic [7:0]  ADDRESS,
    output logic [15:0] IR,
    output logic [7:0]  IR_PC,
    output logic        IR_VALID,
    output logic [4:0]  OPCODE,
    output logic [2:0]  RA,
    output logic [2:0]  COND,
    output logic [2:0]  RB,
    output logic [7:0]  K,
    output logic        HALTED,
    output logic        RAS_ERR
);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_HALTED
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  pc, pc_nxt;
    logic [15:0] ir, ir_nxt;
    logic [7:0]  ir_pc, ir_pc_nxt;
    logic        ir_vld, ir_vld_nxt;

    logic        pop_take;
    logic [7:0]  pop_addr;

`ifdef FETCH_RAS_EN
    localparam int SPW = $clog2(RAS_DEPTH);
    localparam logic [SPW:0] RAS_FULL = (SPW+1)'(RAS_DEPTH);

    logic [7:0]     stack [RAS_DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW:0]   cnt;
    logic           ras_err;
    logic           do_push;

    // A return is only honoured where a redirect is legal and no branch competes.
    assign do_push  = BRANCH_EN & PUSH;
    assign pop_take = POP & ~BRANCH_EN & (state != S_HALTED);
    assign pop_addr = (cnt == '0) ? RESET_PC : stack[sp - SPW'(1)];
    assign RAS_ERR  = ras_err;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sp      <= '0;
            cnt     <= '0;
            ras_err <= 1'b0;
        end else if (do_push) begin
            sp <= sp + SPW'(1);
            if (cnt == RAS_FULL)
                ras_err <= 1'b1;
            else
                cnt <= cnt + (SPW+1)'(1);
        end else if (pop_take) begin
            if (cnt == '0) begin
                ras_err <= 1'b1;
            end else begin
                sp  <= sp - SPW'(1);
                cnt <= cnt - (SPW+1)'(1);
            end
        end
    end

    // Circular write: when full, sp has wrapped onto the oldest entry.
    always_ff @(posedge CLK) begin
        if (do_push)
            stack[sp] <= ir_pc + 8'd1;
    end
`else
    logic unused_ras;

    assign unused_ras = PUSH ^ POP ^ (RAS_DEPTH == 0);
    assign pop_take   = 1'b0;
    assign pop_addr   = RESET_PC;
    assign RAS_ERR    = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= S_FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        ir_pc_nxt  = ir_pc;
        ir_vld_nxt = ir_vld;
        case (state)
            S_FILL, S_RUN: begin
                if (BRANCH_EN || pop_take) begin
                    // Flush the slot already being fetched; target lands in IR next cycle.
                    pc_nxt     = BRANCH_EN ? BRANCH_TARGET : pop_addr;
                    ir_nxt     = 16'h0000;
                    ir_vld_nxt = 1'b0;
                    state_nxt  = S_RUN;
                end else if (state == S_RUN && STALL) begin
                    state_nxt = S_RUN;
                end else if (ir_vld && ir[15:11] == HALT_OPCODE) begin
                    ir_vld_nxt = 1'b0;
                    state_nxt  = S_HALTED;
                end else begin
                    ir_nxt     = DATA;
                    ir_pc_nxt  = pc;
                    pc_nxt     = pc + 8'd1;
                    ir_vld_nxt = 1'b1;
                    state_nxt  = S_RUN;
                end
            end
            S_HALTED: begin
                if (BRANCH_EN) begin
                    pc_nxt     = BRANCH_TARGET;
                    ir_nxt     = 16'h0000;
                    ir_vld_nxt = 1'b0;
                    state_nxt  = S_RUN;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc     <= RESET_PC;
            ir     <= 16'h0000;
            ir_pc  <= 8'h00;
            ir_vld <= 1'b0;
        end else begin
            pc     <= pc_nxt;
            ir     <= ir_nxt;
            ir_pc  <= ir_pc_nxt;
            ir_vld <= ir_vld_nxt;
        end
    end

    assign ADDRESS  = pc;
    assign IR       = ir;
    assign IR_PC    = ir_pc;
    assign IR_VALID = ir_vld;
    assign OPCODE   = ir[15:11];
    assign RA       = ir[10:8];
    assign COND     = ir[10:8];
    assign RB       = ir[2:0];
    assign K        = ir[7:0];
    assign HALTED   = (state == S_HALTED);

endmodule
